bitwise_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-bit bitwise gates.
- One registered datapath performs NOT/AND/OR/XOR/NAND/NOR/XNOR/PASS on WIDTH-bit operands, selected per transaction.
- Valid/ready handshake on both sides, with a one-entry skid buffer so upstream never sees a combinational ready path from out_ready.
- Emits zero/negative flags, as the ALU does, for downstream CPU datapath use.

---
 rtl/bitwise_pkg.sv | 38 +++
 rtl/bitwise_unit_pipe_core.sv | 34 +++
 rtl/bitwise_unit_pipe.sv | 99 +++++++++
 tb/tb_bitwise_unit_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared definitions for the pipelined bitwise unit: op encoding and a
// width-agnostic evaluation function usable by any caller up to MAX_W bits.
package bitwise_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_NOT_A  = 3'd0,
    OP_AND    = 3'd1,
    OP_OR     = 3'd2,
    OP_XOR    = 3'd3,
    OP_NAND   = 3'd4,
    OP_NOR    = 3'd5,
    OP_XNOR   = 3'd6,
    OP_PASS_A = 3'd7
  } op_t;

  // Bitwise ops have no carries, so evaluating at MAX_W and keeping the low
  // bits gives the same answer as evaluating at any narrower width.
  function automatic logic [MAX_W-1:0] bitwise_eval(input op_t op,
                                                    input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    case (op)
      OP_NOT_A: r = ~a;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_unit_pipe_core.sv
// Combinational bitwise datapath: op, a, b -> result plus zero/negative flags.
module bitwise_core
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng
);

  always_comb begin
    // NOTE: default first so every path through the case assigns result; no latch.
    result = '0;
    case (op)
      OP_NOT_A:  result = ~a;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NAND:   result = ~(a & b);
      OP_NOR:    result = ~(a | b);
      OP_XNOR:   result = ~(a ^ b);
      OP_PASS_A: result = a;
      default:   result = '0;
    endcase
  end

  assign zr = (result == '0);
  assign ng = result[WIDTH-1];

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Registered bitwise unit with valid/ready on both sides; a one-entry skid
// buffer keeps in_ready free of any combinational path from out_ready.
module bitwise_unit_pipe
  import bitwise_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit REG_FLAGS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] core_res;
  logic             core_zr;
  logic             core_ng;

  logic             skid_valid;
  logic [WIDTH-1:0] skid_res;
  logic             skid_zr;
  logic             skid_ng;

  logic             out_zr_q;
  logic             out_ng_q;

  logic             accept;
  logic             load_out;

  bitwise_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_t'(op)),
    .a      (a),
    .b      (b),
    .result (core_res),
    .zr     (core_zr),
    .ng     (core_ng)
  );

  assign in_ready = !reset && !skid_valid;
  assign accept   = in_valid && in_ready;
  assign load_out = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out        <= '0;
      out_zr_q   <= 1'b0;
      out_ng_q   <= 1'b0;
    end else begin
      if (load_out) begin
        // Skid entry is older than anything at the input, so it always wins.
        if (skid_valid) begin
          out      <= skid_res;
          out_zr_q <= skid_zr;
          out_ng_q <= skid_ng;
        end else if (accept) begin
          out      <= core_res;
          out_zr_q <= core_zr;
          out_ng_q <= core_ng;
        end
        out_valid  <= skid_valid || accept;
        skid_valid <= 1'b0;
      end else if (accept) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // NOTE: the skid payload is qualified by skid_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && !load_out) begin
      skid_res <= core_res;
      skid_zr  <= core_zr;
      skid_ng  <= core_ng;
    end
  end

  generate
    if (REG_FLAGS) begin : g_reg_flags
      assign zr = out_zr_q;
      assign ng = out_ng_q;
    end else begin : g_comb_flags
      assign zr = (out == '0);
      assign ng = out[WIDTH-1];
    end
  endgenerate

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Bench for bitwise_unit_pipe: directed vector table, backpressure and reset
// sequences, and a random scoreboard run shared by 16-bit, 5-bit and
// combinational-flag instances.
module tb_bitwise_unit_pipe;
  import bitwise_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready;
  logic [2:0]  op;
  logic [15:0] a, b;

  logic        in_ready, out_valid, zr, ng;
  logic [15:0] out;
  logic        in_ready5, out_valid5, zr5, ng5;
  logic [4:0]  out5;
  logic        in_ready_nf, out_valid_nf, zr_nf, ng_nf;
  logic [15:0] out_nf;

  bitwise_unit_pipe #(.WIDTH(16), .REG_FLAGS(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng));

  bitwise_unit_pipe #(.WIDTH(5), .REG_FLAGS(1'b1)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready5),
    .op(op), .a(a[4:0]), .b(b[4:0]), .out_valid(out_valid5), .out_ready(out_ready),
    .out(out5), .zr(zr5), .ng(ng5));

  bitwise_unit_pipe #(.WIDTH(16), .REG_FLAGS(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nf),
    .op(op), .a(a), .b(b), .out_valid(out_valid_nf), .out_ready(out_ready),
    .out(out_nf), .zr(zr_nf), .ng(ng_nf));

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        zr;
    logic        ng;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } txn_t;

  int   errors = 0;
  int   checks = 0;
  txn_t sb_q[$];

  logic        stall_prev = 1'b0;
  logic [15:0] held_out;
  logic        held_zr, held_ng;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One scoreboard cycle: optionally offer a new random transaction, then
  // score whatever handshakes happen on the coming edge.
  task automatic sb_step(input bit gen_new);
    logic        acc, dlv;
    txn_t        t;
    logic [63:0] e;
    if (gen_new && !in_valid) begin
      in_valid = ($urandom_range(0, 3) != 0);
      op       = 3'($urandom);
      a        = 16'($urandom);
      b        = 16'($urandom);
    end
    #1;
    if (stall_prev) begin
      check("stall_out", 64'(out), 64'(held_out));
      check("stall_zr", 64'(zr), 64'(held_zr));
      check("stall_ng", 64'(ng), 64'(held_ng));
    end
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    if (dlv) begin
      check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        t = sb_q.pop_front();
        e = bitwise_eval(op_t'(t.op), MAX_W'(t.a), MAX_W'(t.b));
        check("sb_out", 64'(out), 64'(e[15:0]));
        check("sb_zr", 64'(zr), 64'(e[15:0] == 16'h0));
        check("sb_ng", 64'(ng), 64'(e[15]));
        check("sb_valid5", 64'(out_valid5), 64'd1);
        check("sb_out5", 64'(out5), 64'(e[4:0]));
        check("sb_zr5", 64'(zr5), 64'(e[4:0] == 5'h0));
        check("sb_ng5", 64'(ng5), 64'(e[4]));
        check("sb_valid_nf", 64'(out_valid_nf), 64'd1);
        check("sb_out_nf", 64'(out_nf), 64'(e[15:0]));
        check("sb_zr_nf", 64'(zr_nf), 64'(e[15:0] == 16'h0));
      end
    end
    if (acc) sb_q.push_back('{op: op, a: a, b: b});
    stall_prev = out_valid && !out_ready;
    held_out   = out;
    held_zr    = zr;
    held_ng    = ng;
    tick();
    if (acc) in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[11];
    vecs[0]  = '{op: 3'd0, a: 16'h00FF, b: 16'h0000, out: 16'hFF00, zr: 1'b0, ng: 1'b1};
    vecs[1]  = '{op: 3'd0, a: 16'hF0F0, b: 16'hFF00, out: 16'h0F0F, zr: 1'b0, ng: 1'b0};
    vecs[2]  = '{op: 3'd1, a: 16'hF0F0, b: 16'hFF00, out: 16'hF000, zr: 1'b0, ng: 1'b1};
    vecs[3]  = '{op: 3'd2, a: 16'hF0F0, b: 16'hFF00, out: 16'hFFF0, zr: 1'b0, ng: 1'b1};
    vecs[4]  = '{op: 3'd3, a: 16'hF0F0, b: 16'hFF00, out: 16'h0FF0, zr: 1'b0, ng: 1'b0};
    vecs[5]  = '{op: 3'd4, a: 16'hF0F0, b: 16'hFF00, out: 16'h0FFF, zr: 1'b0, ng: 1'b0};
    vecs[6]  = '{op: 3'd5, a: 16'hF0F0, b: 16'hFF00, out: 16'h000F, zr: 1'b0, ng: 1'b0};
    vecs[7]  = '{op: 3'd6, a: 16'hF0F0, b: 16'hFF00, out: 16'hF00F, zr: 1'b0, ng: 1'b1};
    vecs[8]  = '{op: 3'd7, a: 16'hF0F0, b: 16'hFF00, out: 16'hF0F0, zr: 1'b0, ng: 1'b1};
    vecs[9]  = '{op: 3'd1, a: 16'h0F0F, b: 16'hF0F0, out: 16'h0000, zr: 1'b1, ng: 1'b0};
    vecs[10] = '{op: 3'd7, a: 16'h8000, b: 16'h1234, out: 16'h8000, zr: 1'b0, ng: 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    @(negedge clk);
    check("rst_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_zr", 64'(zr), 64'd0);
    check("rst_ng", 64'(ng), 64'd0);
    check("rst_nf_zr", 64'(zr_nf), 64'd1);
    check("rst_nf_ng", 64'(ng_nf), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Back-to-back vectors with out_ready high: each result one cycle later.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_out", i), 64'(out), 64'(vecs[i].out));
      check($sformatf("vec%0d_zr", i), 64'(zr), 64'(vecs[i].zr));
      check($sformatf("vec%0d_ng", i), 64'(ng), 64'(vecs[i].ng));
      check($sformatf("vec%0d_nf_zr", i), 64'(zr_nf), 64'(vecs[i].zr));
      check($sformatf("vec%0d_nf_ng", i), 64'(ng_nf), 64'(vecs[i].ng));
    end
    in_valid = 1'b0;
    tick();
    check("vec_drained", 64'(out_valid), 64'd0);

    // Backpressure: two accepted, third held off until a delivery.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd3; a = 16'h1234; b = 16'h00FF;
    #1 check("bp_a_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_a_out", 64'(out), 64'h12CB);
    op = 3'd2; a = 16'h0F00; b = 16'h00F0;
    #1 check("bp_b_ready", 64'(in_ready), 64'd1);
    tick();
    op = 3'd4; a = 16'hFFFF; b = 16'hFFFF;
    #1 check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_hold1_out", 64'(out), 64'h12CB);
    tick();
    check("bp_full_ready2", 64'(in_ready), 64'd0);
    check("bp_hold2_out", 64'(out), 64'h12CB);
    check("bp_hold2_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_b_out", 64'(out), 64'h0FF0);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_c_out", 64'(out), 64'h0000);
    check("bp_c_zr", 64'(zr), 64'd1);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Random stress with a shared scoreboard across all three instances.
    stall_prev = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      sb_step(1'b1);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (in_valid || sb_q.size() != 0); c++) sb_step(1'b1 & in_valid);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) sb_step(1'b0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    stall_prev = 1'b0;

    // Reset with both output register and skid occupied.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd3; a = 16'h1111; b = 16'h2222;
    tick();
    op = 3'd2; a = 16'hAAAA; b = 16'h5555;
    tick();
    in_valid = 1'b0;
    #1;
    check("mid_skid_full", 64'(in_ready), 64'd0);
    check("mid_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1 check("mid_rst_ready", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out", 64'(out), 64'd0);
    check("mid_rst_zr", 64'(zr), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_in_ready5", 64'(in_ready5), 64'd1);
    check("mid_rst_in_ready_nf", 64'(in_ready_nf), 64'd1);
    check("mid_rst_nf_zr", 64'(zr_nf), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("mid_no_stale%0d", c), 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
